// File: rtl/tpu_pkg.sv
// tpu_pkg: shared run-state type and arithmetic helpers for TPU datapath blocks
package tpu_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} run_state_t;
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v, input int width, input logic relu);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    return (relu && v < 64'sd0) ? 64'sd0 : (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/pe_acc.sv
// pe_acc: one output-stationary PE, multiply-accumulate with registered a/b forwarding
module pe_acc import tpu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, 2)
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [WIDTH-1:0]     a_fwd,
  output logic signed [WIDTH-1:0]     b_fwd,
  output logic signed [ACC_WIDTH-1:0] sum
);
  logic signed [ACC_WIDTH-1:0] acc;
  assign sum = acc + ACC_WIDTH'(a) * ACC_WIDTH'(b);
  // accumulate every cycle; idle cycles carry zeros so they add nothing
  always_ff @(posedge clk) begin
    acc   <= clr ? '0 : sum;
    a_fwd <= clr ? '0 : a;
    b_fwd <= clr ? '0 : b;
  end
endmodule

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: NxN output-stationary matmul with internal skew, run FSM and saturating output
module systolic_array_nxn import tpu_pkg::*; #(
  parameter int N = 2,
  parameter int WIDTH = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 activation,
  input  logic [N*WIDTH-1:0]   a_col,
  input  logic [N*WIDTH-1:0]   b_row,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*N*WIDTH-1:0] c_flat,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(2 * N);
  run_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic act, xfer, clr, last_drain;
  logic signed [WIDTH-1:0] a_g [N], b_g [N], a_lead [N], b_lead [N];
  logic signed [WIDTH-1:0] a_sr [N][N], b_sr [N][N];
  logic signed [WIDTH-1:0] a_h [N][N], b_v [N][N];
  logic signed [ACC_WIDTH-1:0] sum [N][N];
  assign in_ready   = state == LOAD;
  assign busy       = state == CLEAR || state == LOAD || state == DRAIN;
  assign done       = state == DONE;
  assign xfer       = in_valid && in_ready;
  assign clr        = !rst || state == CLEAR;
  assign last_drain = state == DRAIN && cnt == CW'(2 * N - 3);
  // run sequencing: count beats in LOAD, then fixed-length drain until the farthest PE is fed
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE:  state_nxt = start ? CLEAR : IDLE;
      CLEAR: begin
        state_nxt = LOAD;
        cnt_nxt = '0;
      end
      LOAD:  if (xfer) begin
        state_nxt = cnt == CW'(N - 1) ? DRAIN : LOAD;
        cnt_nxt = cnt == CW'(N - 1) ? '0 : cnt + 1'b1;
      end
      DRAIN: begin
        state_nxt = last_drain ? DONE : DRAIN;
        cnt_nxt = cnt + 1'b1;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, beat/drain counter and the ReLU mode latched for the run
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      act <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (state == IDLE && start) act <= activation;
    end
  end
  // only accepted beats enter the array; everything else injects zeros
  always_comb
    for (int i = 0; i < N; i++) begin
      a_g[i] = xfer ? a_col[i*WIDTH +: WIDTH] : '0;
      b_g[i] = xfer ? b_row[i*WIDTH +: WIDTH] : '0;
    end
  // skew shift registers: lane i is tapped after i stages
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++) begin
      a_sr[i][0] <= clr ? '0 : a_g[i];
      b_sr[i][0] <= clr ? '0 : b_g[i];
      for (int s = 1; s < N; s++) begin
        a_sr[i][s] <= clr ? '0 : a_sr[i][s-1];
        b_sr[i][s] <= clr ? '0 : b_sr[i][s-1];
      end
    end
  for (genvar i = 0; i < N; i++) begin : g_row
    if (i == 0) begin : g_head
      assign a_lead[i] = a_g[i];
      assign b_lead[i] = b_g[i];
    end else begin : g_skew
      assign a_lead[i] = a_sr[i][i-1];
      assign b_lead[i] = b_sr[i][i-1];
    end
    logic unused_edge;
    assign unused_edge = ^{a_h[i][N-1], b_v[N-1][i]};
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [WIDTH-1:0] a_i, b_i;
      if (j == 0) begin : g_al
        assign a_i = a_lead[i];
      end else begin : g_an
        assign a_i = a_h[i][j-1];
      end
      if (i == 0) begin : g_bl
        assign b_i = b_lead[j];
      end else begin : g_bn
        assign b_i = b_v[i-1][j];
      end
      pe_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk, .clr, .a(a_i), .b(b_i), .a_fwd(a_h[i][j]), .b_fwd(b_v[i][j]), .sum(sum[i][j])
      );
    end
  end
  // capture the final sums (including the last in-flight product) on the edge into DONE
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!rst) c_flat[(i*N+j)*WIDTH +: WIDTH] <= '0;
        else if (last_drain) c_flat[(i*N+j)*WIDTH +: WIDTH] <= WIDTH'(sat_relu(64'(sum[i][j]), WIDTH, act));
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: table-driven and randomized checks of the NxN systolic engine (N=2 and N=4)
module tb_systolic_array_nxn;
  logic clk = 0, rst = 0, st2 = 0, st4 = 0, activation = 0, in_valid = 0;
  logic [31:0] a_col = '0, b_row = '0;
  logic in_ready2, in_ready4, busy2, busy4, done2, done4;
  logic [31:0] c_flat2;
  logic [127:0] c_flat4;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic act;
    logic [0:3][7:0] a;
    logic [0:3][7:0] b;
    logic [0:3][7:0] c;
  } vec_t;
  vec_t tbl [7];
  int a [4][4], b [4][4];

  always #5 clk = ~clk;

  systolic_array_nxn #(.N(2), .WIDTH(8)) u2 (
    .clk, .rst, .start(st2), .activation, .a_col(a_col[15:0]), .b_row(b_row[15:0]), .in_valid,
    .in_ready(in_ready2), .c_flat(c_flat2), .busy(busy2), .done(done2));
  systolic_array_nxn #(.N(4), .WIDTH(8)) u4 (
    .clk, .rst, .start(st4), .activation, .a_col, .b_row, .in_valid,
    .in_ready(in_ready4), .c_flat(c_flat4), .busy(busy4), .done(done4));

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int cval(input int n, input int i, input int j);
    return n == 2 ? int'($signed(c_flat2[(i*2+j)*8 +: 8])) : int'($signed(c_flat4[(i*4+j)*8 +: 8]));
  endfunction

  // plain matrix product, then clamp to int8 and optional ReLU
  function automatic void model(input int n, input int ma [4][4], input int mb [4][4], input bit relu, output int mc [4][4]);
    mc = '{default: 0};
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int s = 0;
        for (int k = 0; k < n; k++) s += ma[i][k] * mb[k][j];
        s = s > 127 ? 127 : s < -128 ? -128 : s;
        mc[i][j] = (relu && s < 0) ? 0 : s;
      end
  endfunction

  task automatic run(input int n, input int ma [4][4], input int mb [4][4], input bit relu, input int gap_pct, input bit poke);
    int lat, last, k;
    int want [4][4];
    logic [127:0] snap;
    bit hold_ok, busy_ok;
    model(n, ma, mb, relu, want);
    snap = n == 2 ? {96'b0, c_flat2} : c_flat4;
    activation = relu;
    if (n == 2) st2 = 1; else st4 = 1;
    @(negedge clk);
    lat = 1; k = 0; last = -1; hold_ok = 1; busy_ok = 1;
    st2 = poke && n == 2;
    st4 = poke && n == 4;
    while (!(n == 2 ? done2 : done4) && lat < 100) begin
      if (!(n == 2 ? busy2 : busy4)) busy_ok = 0;
      if ((n == 2 ? {96'b0, c_flat2} : c_flat4) !== snap) hold_ok = 0;
      a_col = $urandom;
      b_row = $urandom;
      activation = 1'($urandom);
      in_valid = 0;
      if ((n == 2 ? in_ready2 : in_ready4) && k < n && int'($urandom_range(99)) >= gap_pct) begin
        for (int i = 0; i < n; i++) begin
          a_col[i*8 +: 8] = 8'(ma[i][k]);
          b_row[i*8 +: 8] = 8'(mb[k][i]);
        end
        in_valid = 1;
        last = lat;
        k++;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    chk("done_latency", lat, last + 2 * n - 1);
    chk("busy_during_run", int'(busy_ok), 1);
    chk("c_flat_hold", int'(hold_ok), 1);
    chk("busy_in_done", int'(n == 2 ? busy2 : busy4), 0);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        chk($sformatf("n%0d_c%0d%0d", n, i, j), cval(n, i, j), want[i][j]);
    if (poke) begin
      @(negedge clk);
      chk("start_ignored", int'(n == 2 ? (busy2 | done2) : (busy4 | done4)), 0);
      st2 = 0;
      st4 = 0;
    end
  endtask

  task automatic rand_mats();
    a = '{default: 0};
    b = '{default: 0};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = int'($urandom_range(255)) - 128;
        b[i][j] = int'($urandom_range(255)) - 128;
      end
  endtask

  initial begin
    tbl[0] = '{act: 1'b0, a: {8'd1, 8'd2, 8'd3, 8'd4}, b: {8'd5, 8'd6, 8'd7, 8'd8}, c: {8'd19, 8'd22, 8'd43, 8'd50}};
    tbl[1] = '{act: 1'b1, a: {8'(-1), 8'd2, 8'd3, 8'(-4)}, b: {8'd1, 8'd0, 8'd0, 8'd1}, c: {8'd0, 8'd2, 8'd3, 8'd0}};
    tbl[2] = '{act: 1'b0, a: {8'(-1), 8'd2, 8'd3, 8'(-4)}, b: {8'd1, 8'd0, 8'd0, 8'd1}, c: {8'(-1), 8'd2, 8'd3, 8'(-4)}};
    tbl[3] = '{act: 1'b0, a: {4{8'd127}}, b: {4{8'd127}}, c: {4{8'd127}}};
    tbl[4] = '{act: 1'b0, a: {4{8'(-128)}}, b: {4{8'd127}}, c: {4{8'(-128)}}};
    tbl[5] = '{act: 1'b0, a: {4{8'(-128)}}, b: {4{8'(-128)}}, c: {4{8'd127}}};
    tbl[6] = '{act: 1'b1, a: {4{8'(-128)}}, b: {4{8'd127}}, c: {4{8'd0}}};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready2 | in_ready4), 0);
    chk("rst_busy", int'(busy2 | busy4), 0);
    chk("rst_done", int'(done2 | done4), 0);
    chk("rst_c_flat", int'(c_flat2 != '0 || c_flat4 != '0), 0);
    rst = 1;
    @(negedge clk);
    for (int t = 0; t < 7; t++) begin
      a = '{default: 0};
      b = '{default: 0};
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++) begin
          a[i][k] = int'($signed(tbl[t].a[i*2+k]));
          b[i][k] = int'($signed(tbl[t].b[i*2+k]));
        end
      run(2, a, b, tbl[t].act, 0, 0);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          chk($sformatf("tbl%0d_c%0d%0d", t, i, j), cval(2, i, j), int'($signed(tbl[t].c[i*2+j])));
      @(negedge clk);
    end
    for (int r = 0; r < 4; r++) begin
      rand_mats();
      run(4, a, b, bit'(r % 2), 30, r == 0);
      @(negedge clk);
    end
    st4 = 1;
    @(negedge clk);
    st4 = 0;
    for (int w = 0; w < 10 && !in_ready4; w++) @(negedge clk);
    chk("mid_ready_wait", int'(in_ready4), 1);
    a_col = 32'h7f7f7f7f;
    b_row = 32'h7f7f7f7f;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy4), 0);
    chk("mid_rst_in_ready", int'(in_ready4), 0);
    chk("mid_rst_c_flat", int'(c_flat4 != '0), 0);
    rst = 1;
    @(negedge clk);
    rand_mats();
    run(4, a, b, 1'b0, 30, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
